bp_update_ctrl: RTL

BP_UPDATE_CTRL -- requirements
Module: bp_update_ctrl

---
 rtl/bp_pkg.sv | 31 +++
 rtl/bp_inflight_fifo.sv | 52 +++++
 rtl/bp_update_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit counter encodings, in-flight entry, counter update.
package bp_pkg;

   // Widest predictor index an in-flight entry can carry; IDX_W of a user must not exceed it.
   localparam int unsigned BP_IDX_MAX_W = 16;

   typedef enum logic [1:0] {
      STRONG_T = 2'd0,
      WEAK_T   = 2'd1,
      WEAK_N   = 2'd2,
      STRONG_N = 2'd3
   } bp_fsm_e;

   typedef struct packed {
      logic [BP_IDX_MAX_W-1:0] addr;
      logic [1:0]              fsm;
      logic                    pred_taken;
   } bp_entry_t;

   // Saturating move: a taken outcome pulls toward STRONG_T, not-taken toward STRONG_N.
   function automatic logic [1:0] bp_next_fsm(input logic [1:0] fsm, input logic taken);
      logic [1:0] nxt;
      if (taken) begin
         nxt = (fsm == 2'(STRONG_T)) ? fsm : fsm - 2'd1;
      end else begin
         nxt = (fsm == 2'(STRONG_N)) ? fsm : fsm + 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of branches between prediction and resolution.
module bp_inflight_fifo
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  logic      clear,
   input  bp_entry_t din,
   output logic      full,
   output logic      empty,
   output bp_entry_t head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   bp_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Pointers wrap naturally at DEPTH; clear drops everything including a same-cycle push.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage, written only on accepted pushes.
   always_ff @(posedge clk) begin
      if (push && !clear && !rst) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/bp_update_ctrl.sv
// Tracks in-flight branches and writes trained counters back to the predictor table.
module bp_update_ctrl
   import bp_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned IDX_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic             id_stall,
   input  logic [IDX_W-1:0] id_addr,
   input  logic [1:0]       id_fsm,
   input  logic             res_valid,
   input  logic             res_mispredict,
   output logic             id_stall_req,
   output logic             pipe_flush,
   output logic             upd_we,
   output logic [IDX_W-1:0] upd_addr,
   output logic [1:0]       upd_value,
   output logic [31:0]      branch_cnt,
   output logic [31:0]      miss_cnt,
   output logic             res_orphan
);

   logic      full;
   logic      empty;
   logic      push;
   logic      pop;
   logic      flush_c;
   bp_entry_t din;
   bp_entry_t head;
   logic [1:0] new_fsm;
   logic      unused_addr_hi;

   // A resolution only acts on a real head; a mispredict kills the rest of the queue and
   // any branch arriving in the same cycle. A full queue still accepts while it drains.
   assign pop          = res_valid && !empty;
   assign flush_c      = pop && res_mispredict;
   assign push         = id_valid && !id_stall && !(res_valid && res_mispredict)
                         && (!full || pop);
   assign id_stall_req = full && id_valid;

   assign din = '{addr:       BP_IDX_MAX_W'(id_addr),
                  fsm:        id_fsm,
                  pred_taken: ~id_fsm[1]};

   // Actual direction is the prediction flipped by a mispredict.
   assign new_fsm        = bp_next_fsm(head.fsm, head.pred_taken ^ res_mispredict);
   assign unused_addr_hi = ^head.addr;

   bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clear (flush_c),
      .din   (din),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   // Registered table write, flush pulse, statistics and orphan flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         upd_we     <= 1'b0;
         upd_addr   <= '0;
         upd_value  <= '0;
         pipe_flush <= 1'b0;
         branch_cnt <= '0;
         miss_cnt   <= '0;
         res_orphan <= 1'b0;
      end else begin
         upd_we     <= pop && (new_fsm != head.fsm);
         pipe_flush <= flush_c;
         if (pop) begin
            upd_addr  <= head.addr[IDX_W-1:0];
            upd_value <= new_fsm;
         end
         if (push)    branch_cnt <= branch_cnt + 32'd1;
         if (flush_c) miss_cnt   <= miss_cnt + 32'd1;
         if (res_valid && empty) res_orphan <= 1'b1;
      end
   end

endmodule
